// File: rtl/msrv32_ahb_arbiter_if.sv
// msrv32_ahb_arbiter_if
// Bundles every bus-side signal of the two-master AHB-lite arbiter.
//   instruction port : i_req_in, i_addr_in -> i_hready_out, i_rvalid_out, i_rdata_out, i_err_out
//   data port        : d_htrans_in, d_addr_in, d_wr_req_in, d_wr_mask_in, d_wdata_in
//                      -> d_hready_out, d_rvalid_out, d_rdata_out, d_hresp_out
//   AHB-lite master  : haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out
//                      <- hrdata_in, hready_in, hresp_in
// Modport master is the arbiter's view; modport slave is the surrounding system's view.
`timescale 1ns/1ps
interface msrv32_ahb_arbiter_if;
    logic        i_req_in;
    logic [31:0] i_addr_in;
    logic        i_hready_out;
    logic        i_rvalid_out;
    logic [31:0] i_rdata_out;
    logic        i_err_out;

    logic [1:0]  d_htrans_in;
    logic [31:0] d_addr_in;
    logic        d_wr_req_in;
    logic [3:0]  d_wr_mask_in;
    logic [31:0] d_wdata_in;
    logic        d_hready_out;
    logic        d_rvalid_out;
    logic [31:0] d_rdata_out;
    logic        d_hresp_out;

    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [31:0] hrdata_in;
    logic        hready_in;
    logic        hresp_in;

    modport master (
        input  i_req_in, i_addr_in,
        output i_hready_out, i_rvalid_out, i_rdata_out, i_err_out,
        input  d_htrans_in, d_addr_in, d_wr_req_in, d_wr_mask_in, d_wdata_in,
        output d_hready_out, d_rvalid_out, d_rdata_out, d_hresp_out,
        output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        input  hrdata_in, hready_in, hresp_in
    );

    modport slave (
        output i_req_in, i_addr_in,
        input  i_hready_out, i_rvalid_out, i_rdata_out, i_err_out,
        output d_htrans_in, d_addr_in, d_wr_req_in, d_wr_mask_in, d_wdata_in,
        input  d_hready_out, d_rvalid_out, d_rdata_out, d_hresp_out,
        input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        output hrdata_in, hready_in, hresp_in
    );
endinterface

// File: rtl/msrv32_ahb_arbiter.sv
// msrv32_ahb_arbiter
// Shares one AHB-lite bus between the instruction-fetch and data ports.
// The address-phase owner is chosen combinationally each cycle (data first,
// unless fetch has been starved for STARVE_LIMIT consecutive data grants);
// the data-phase owner is registered so read data, ready and error are
// steered back to whichever port issued the transfer.
// Ports:
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous active-high reset
//   bus                  : msrv32_ahb_arbiter_if.master (fetch, data and AHB signals)
`timescale 1ns/1ps
module msrv32_ahb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_in,
    msrv32_ahb_arbiter_if.master       bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_t;

    owner_t      dphase_owner_reg, dphase_owner_next;
    owner_t      grant;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic [31:0] hwdata_reg, hwdata_next;
    logic        err_hold_reg, err_hold_next;

    logic d_req;
    logic err_first;

    function automatic logic [2:0] size_of_mask(input logic [3:0] mask);
        case (mask)
            4'b1111:                            size_of_mask = 3'b010;
            4'b0011, 4'b1100:                   size_of_mask = 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of_mask = 3'b000;
            default:                            size_of_mask = 3'b010;
        endcase
    endfunction

    assign d_req     = (bus.d_htrans_in == 2'b10);
    // First cycle of the two-cycle AHB error response: the pending address
    // phase is cancelled by presenting IDLE.
    assign err_first = bus.hresp_in & ~bus.hready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            dphase_owner_reg <= OWN_NONE;
            starve_cnt_reg   <= 4'd0;
            hwdata_reg       <= 32'd0;
            err_hold_reg     <= 1'b0;
        end else begin
            dphase_owner_reg <= dphase_owner_next;
            starve_cnt_reg   <= starve_cnt_next;
            hwdata_reg       <= hwdata_next;
            err_hold_reg     <= err_hold_next;
        end
    end

    // Grant and next-state logic. Reset gates the grant so nothing reaches
    // the bus (and no write data is captured) while reset is held.
    always_comb begin
        grant             = OWN_NONE;
        dphase_owner_next = dphase_owner_reg;
        starve_cnt_next   = starve_cnt_reg;
        hwdata_next       = hwdata_reg;
        err_hold_next     = err_hold_reg;

        if (!ms_riscv32_mp_rst_in && !err_first) begin
            if (d_req && ((starve_cnt_reg < LIMIT) || !bus.i_req_in)) begin
                grant = OWN_DATA;
            end else if (bus.i_req_in) begin
                grant = OWN_INSTR;
            end
        end

        if (bus.hready_in) begin
            dphase_owner_next = grant;
            if (grant == OWN_INSTR) begin
                starve_cnt_next = 4'd0;
            end else if (grant == OWN_DATA && bus.i_req_in) begin
                starve_cnt_next = (starve_cnt_reg >= LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
            end else if (!bus.i_req_in) begin
                starve_cnt_next = 4'd0;
            end
            if (grant == OWN_DATA && bus.d_wr_req_in) begin
                hwdata_next = bus.d_wdata_in;
            end
        end

        if (err_first) begin
            err_hold_next = 1'b1;
        end else if (bus.hready_in) begin
            err_hold_next = 1'b0;
        end
    end

    // Address-phase outputs follow the current grant.
    always_comb begin
        bus.htrans_out = 2'b00;
        bus.haddr_out  = bus.i_addr_in;
        bus.hwrite_out = 1'b0;
        bus.hsize_out  = 3'b010;
        case (grant)
            OWN_INSTR: begin
                bus.htrans_out = 2'b10;
            end
            OWN_DATA: begin
                bus.htrans_out = 2'b10;
                bus.haddr_out  = bus.d_addr_in;
                bus.hwrite_out = bus.d_wr_req_in;
                // Loads always fetch a full word; the core extracts the lanes.
                bus.hsize_out  = bus.d_wr_req_in ? size_of_mask(bus.d_wr_mask_in) : 3'b010;
            end
            default: ;
        endcase
    end

    assign bus.hwdata_out   = hwdata_reg;

    assign bus.i_hready_out = bus.hready_in & (grant == OWN_INSTR);
    assign bus.d_hready_out = bus.hready_in & ~ms_riscv32_mp_rst_in & ((grant == OWN_DATA) | ~d_req);

    assign bus.i_rvalid_out = bus.hready_in & ~bus.hresp_in & ~ms_riscv32_mp_rst_in & (dphase_owner_reg == OWN_INSTR);
    assign bus.d_rvalid_out = bus.hready_in & ~bus.hresp_in & ~ms_riscv32_mp_rst_in & (dphase_owner_reg == OWN_DATA);
    assign bus.i_rdata_out  = bus.hrdata_in;
    assign bus.d_rdata_out  = bus.hrdata_in;
    assign bus.i_err_out    = bus.hresp_in & ~ms_riscv32_mp_rst_in & (dphase_owner_reg == OWN_INSTR);
    assign bus.d_hresp_out  = bus.hresp_in & ~ms_riscv32_mp_rst_in & (dphase_owner_reg == OWN_DATA);
endmodule

// File: tb/tb_msrv32_ahb_arbiter.sv
`timescale 1ns/1ps
module tb_msrv32_ahb_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    msrv32_ahb_arbiter_if bus_if ();

    msrv32_ahb_arbiter #(.STARVE_LIMIT(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic [1:0]  d_htrans;
        logic [31:0] d_addr;
        logic        d_wr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic        hready;
        logic        hresp;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic [2:0]  e_hsize;
        logic [5:0]  e_flags;   // {i_hready, d_hready, i_rvalid, d_rvalid, i_err, d_hresp}
        logic [31:0] e_hwdata;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(
        input logic i_req, input logic [31:0] i_addr, input logic [1:0] d_htrans,
        input logic [31:0] d_addr, input logic d_wr, input logic [3:0] mask,
        input logic [31:0] wdata, input logic [31:0] hrdata, input logic hready,
        input logic hresp, input logic [1:0] e_htrans, input logic [31:0] e_haddr,
        input logic e_hwrite, input logic [2:0] e_hsize, input logic [5:0] e_flags,
        input logic [31:0] e_hwdata);
        vec_t v;
        v.i_req = i_req;       v.i_addr = i_addr;     v.d_htrans = d_htrans;
        v.d_addr = d_addr;     v.d_wr = d_wr;         v.mask = mask;
        v.wdata = wdata;       v.hrdata = hrdata;     v.hready = hready;
        v.hresp = hresp;       v.e_htrans = e_htrans; v.e_haddr = e_haddr;
        v.e_hwrite = e_hwrite; v.e_hsize = e_hsize;   v.e_flags = e_flags;
        v.e_hwdata = e_hwdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(
        input logic i_req, input logic [31:0] i_addr, input logic [1:0] d_htrans,
        input logic [31:0] d_addr, input logic d_wr, input logic [3:0] mask,
        input logic [31:0] wdata, input logic [31:0] hrdata, input logic hready,
        input logic hresp);
        bus_if.i_req_in     = i_req;
        bus_if.i_addr_in    = i_addr;
        bus_if.d_htrans_in  = d_htrans;
        bus_if.d_addr_in    = d_addr;
        bus_if.d_wr_req_in  = d_wr;
        bus_if.d_wr_mask_in = mask;
        bus_if.d_wdata_in   = wdata;
        bus_if.hrdata_in    = hrdata;
        bus_if.hready_in    = hready;
        bus_if.hresp_in     = hresp;
    endtask

    function automatic logic [31:0] flags();
        return {26'd0, bus_if.i_hready_out, bus_if.d_hready_out, bus_if.i_rvalid_out,
                bus_if.d_rvalid_out, bus_if.i_err_out, bus_if.d_hresp_out};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = mk(0, 32'h0,   2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h0,        1, 0, 2'b00, 32'h0,   0, 3'b010, 6'b010000, 32'h0);
        vecs[1]  = mk(1, 32'h0,   2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h11111111, 1, 0, 2'b10, 32'h0,   0, 3'b010, 6'b110000, 32'h0);
        vecs[2]  = mk(1, 32'h4,   2'b00, 32'h0,   0, 4'h0, 32'h0,        32'hA0A0A0A0, 1, 0, 2'b10, 32'h4,   0, 3'b010, 6'b111000, 32'h0);
        vecs[3]  = mk(1, 32'h8,   2'b00, 32'h0,   0, 4'h0, 32'h0,        32'hB0B0B0B0, 1, 0, 2'b10, 32'h8,   0, 3'b010, 6'b111000, 32'h0);
        vecs[4]  = mk(1, 32'hC,   2'b10, 32'h103, 1, 4'h8, 32'hAA000000, 32'hC0C0C0C0, 1, 0, 2'b10, 32'h103, 1, 3'b000, 6'b011000, 32'h0);
        vecs[5]  = mk(1, 32'hC,   2'b00, 32'h0,   0, 4'h0, 32'h0,        32'hD0D0D0D0, 1, 0, 2'b10, 32'hC,   0, 3'b010, 6'b110100, 32'hAA000000);
        vecs[6]  = mk(0, 32'h10,  2'b10, 32'h200, 1, 4'h3, 32'h00001234, 32'hE0E0E0E0, 1, 0, 2'b10, 32'h200, 1, 3'b001, 6'b011000, 32'hAA000000);
        vecs[7]  = mk(0, 32'h10,  2'b10, 32'h300, 0, 4'h1, 32'hFFFFFFFF, 32'h0F0F0F0F, 1, 0, 2'b10, 32'h300, 0, 3'b010, 6'b010100, 32'h00001234);
        vecs[8]  = mk(0, 32'h10,  2'b10, 32'h400, 1, 4'h6, 32'h00000055, 32'h12345678, 1, 0, 2'b10, 32'h400, 1, 3'b010, 6'b010100, 32'h00001234);
        vecs[9]  = mk(0, 32'h10,  2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h00000009, 1, 0, 2'b00, 32'h10,  0, 3'b010, 6'b010100, 32'h00000055);
        vecs[10] = mk(0, 32'h10,  2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h00000008, 1, 0, 2'b00, 32'h10,  0, 3'b010, 6'b010000, 32'h00000055);
        vecs[11] = mk(0, 32'h10,  2'b10, 32'h500, 1, 4'hC, 32'h66660000, 32'h00000007, 1, 0, 2'b10, 32'h500, 1, 3'b001, 6'b010000, 32'h00000055);
        vecs[12] = mk(1, 32'h14,  2'b10, 32'h504, 1, 4'h4, 32'h00000077, 32'h00000006, 1, 0, 2'b10, 32'h504, 1, 3'b000, 6'b010100, 32'h66660000);
        vecs[13] = mk(0, 32'h14,  2'b00, 32'h0,   0, 4'h0, 32'h0,        32'h00000005, 1, 0, 2'b00, 32'h14,  0, 3'b010, 6'b010100, 32'h00000077);

        // Reset: a granted-looking write must not reach the bus or hwdata.
        rst = 1'b1;
        drive(1, 32'h40, 2'b10, 32'h80, 1, 4'hF, 32'hDEADBEEF, 32'h0, 1, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst.htrans", {30'd0, bus_if.htrans_out}, 32'h0);
        chk("rst.flags", flags(), 32'h0);
        chk("rst.hwdata", bus_if.hwdata_out, 32'h0);
        rst = 1'b0;

        // Table: fetch stream, byte store, halfword store, load, odd masks.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].i_req, vecs[i].i_addr, vecs[i].d_htrans, vecs[i].d_addr, vecs[i].d_wr,
                  vecs[i].mask, vecs[i].wdata, vecs[i].hrdata, vecs[i].hready, vecs[i].hresp);
            #2;
            chk($sformatf("v%0d.htrans", i), {30'd0, bus_if.htrans_out}, {30'd0, vecs[i].e_htrans});
            chk($sformatf("v%0d.haddr", i), bus_if.haddr_out, vecs[i].e_haddr);
            chk($sformatf("v%0d.hwrite", i), {31'd0, bus_if.hwrite_out}, {31'd0, vecs[i].e_hwrite});
            chk($sformatf("v%0d.hsize", i), {29'd0, bus_if.hsize_out}, {29'd0, vecs[i].e_hsize});
            chk($sformatf("v%0d.flags", i), flags(), {26'd0, vecs[i].e_flags});
            chk($sformatf("v%0d.hwdata", i), bus_if.hwdata_out, vecs[i].e_hwdata);
            if (vecs[i].e_flags[3] || vecs[i].e_flags[2]) begin
                chk($sformatf("v%0d.i_rdata", i), bus_if.i_rdata_out, vecs[i].hrdata);
                chk($sformatf("v%0d.d_rdata", i), bus_if.d_rdata_out, vecs[i].hrdata);
            end
            $display("vec %0d htrans=%b haddr=%h flags=%b", i, bus_if.htrans_out, bus_if.haddr_out, flags());
            next_cycle();
        end

        // Starvation: both requesting for 10 cycles -> D,D,D,D,I repeated.
        for (int k = 0; k < 10; k++) begin
            logic instr_turn;
            instr_turn = (k % 5 == 4);
            drive(1, 32'h20, 2'b10, 32'h500, 0, 4'hF, 32'h0, 32'h0, 1, 0);
            #2;
            chk($sformatf("starve%0d.htrans", k), {30'd0, bus_if.htrans_out}, 32'h2);
            chk($sformatf("starve%0d.haddr", k), bus_if.haddr_out, instr_turn ? 32'h20 : 32'h500);
            chk($sformatf("starve%0d.i_hready", k), {31'd0, bus_if.i_hready_out}, {31'd0, instr_turn});
            chk($sformatf("starve%0d.d_hready", k), {31'd0, bus_if.d_hready_out}, {31'd0, ~instr_turn});
            $display("starve %0d grant=%s", k, bus_if.i_hready_out ? "I" : "D");
            next_cycle();
        end

        // Wait states during a data load's data phase.
        drive(0, 32'h0, 2'b10, 32'h600, 0, 4'hF, 32'h0, 32'h0, 1, 0);
        #2;
        chk("ws0.haddr", bus_if.haddr_out, 32'h600);
        chk("ws0.i_rvalid", {31'd0, bus_if.i_rvalid_out}, 32'h1);
        $display("ws 0 haddr=%h", bus_if.haddr_out);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 32'h0, 2'b10, 32'h604, 0, 4'hF, 32'h0, 32'hBAD0BAD0, 0, 0);
            #2;
            chk($sformatf("ws%0d.htrans", k), {30'd0, bus_if.htrans_out}, 32'h2);
            chk($sformatf("ws%0d.haddr", k), bus_if.haddr_out, 32'h604);
            chk($sformatf("ws%0d.flags", k), flags(), 32'h0);
            $display("ws %0d haddr=%h flags=%b", k, bus_if.haddr_out, flags());
            next_cycle();
        end
        drive(0, 32'h0, 2'b10, 32'h604, 0, 4'hF, 32'h0, 32'hCAFEF00D, 1, 0);
        #2;
        chk("ws4.haddr", bus_if.haddr_out, 32'h604);
        chk("ws4.flags", flags(), 32'b010100);
        chk("ws4.d_rdata", bus_if.d_rdata_out, 32'hCAFEF00D);
        $display("ws 4 flags=%b rdata=%h", flags(), bus_if.d_rdata_out);
        next_cycle();
        drive(0, 32'h0, 2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h00001357, 1, 0);
        #2;
        chk("ws5.flags", flags(), 32'b010100);
        $display("ws 5 flags=%b", flags());
        next_cycle();

        // Two-cycle error response on a data phase.
        drive(0, 32'h0, 2'b10, 32'h700, 0, 4'hF, 32'h0, 32'h0, 1, 0);
        #2;
        chk("err0.htrans", {30'd0, bus_if.htrans_out}, 32'h2);
        $display("err 0 htrans=%b", bus_if.htrans_out);
        next_cycle();
        drive(1, 32'h50, 2'b10, 32'h704, 0, 4'hF, 32'h0, 32'h0, 0, 1);
        #2;
        chk("err1.htrans", {30'd0, bus_if.htrans_out}, 32'h0);
        chk("err1.flags", flags(), 32'b000001);
        $display("err 1 htrans=%b flags=%b", bus_if.htrans_out, flags());
        next_cycle();
        drive(0, 32'h50, 2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
        #2;
        chk("err2.flags", flags(), 32'b010001);
        $display("err 2 flags=%b", flags());
        next_cycle();
        drive(0, 32'h50, 2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        #2;
        chk("err3.flags", flags(), 32'b010000);
        $display("err 3 flags=%b", flags());
        next_cycle();

        // Asynchronous reset in the middle of a fetch.
        drive(1, 32'h40, 2'b00, 32'h0, 0, 4'h0, 32'h0, 32'h24682468, 1, 0);
        next_cycle();
        #1;
        chk("arst.pre_i_rvalid", {31'd0, bus_if.i_rvalid_out}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst.htrans", {30'd0, bus_if.htrans_out}, 32'h0);
        chk("arst.flags", flags(), 32'h0);
        rst = 1'b0;
        #1;
        chk("arst.post_htrans", {30'd0, bus_if.htrans_out}, 32'h2);
        chk("arst.post_haddr", bus_if.haddr_out, 32'h40);
        chk("arst.post_flags", flags(), 32'b110000);
        $display("arst released htrans=%b flags=%b", bus_if.htrans_out, flags());
        @(posedge clk);
        #2;
        chk("arst.next_i_rvalid", {31'd0, bus_if.i_rvalid_out}, 32'h1);
        $display("arst next flags=%b", flags());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
